// File: rtl/alarm_controller.sv
// Intrusion alarm FSM: DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM, with tick-driven delays.
// Optional feature macro: ALARM_TIMEOUT_EN (ALARM auto-rearms after ALARM_TICKS ticks).
module alarm_controller #(
  parameter int EXIT_TICKS  = 10,
  parameter int ENTRY_TICKS = 8,
  parameter int ALARM_TICKS = 15,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       arm,
  input  logic       disarm,
  input  logic       sensor,
  output logic [2:0] state,
  output logic       armed,
  output logic       siren,
  output logic       chirp
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

`ifdef ALARM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CW-1:0] EXIT_LAST  = CW'(EXIT_TICKS - 1);
  localparam logic [CW-1:0] ENTRY_LAST = CW'(ENTRY_TICKS - 1);
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_TICKS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed;
  logic          armed_q, siren_q, chirp_q;

  always_comb begin
    state_d = S_DISARMED;
    timed   = 1'b0;
    case (state_q)
      S_DISARMED: state_d = arm ? S_EXIT : S_DISARMED;
      S_EXIT: begin
        timed   = 1'b1;
        state_d = (tick && cnt_q == EXIT_LAST) ? S_ARMED : S_EXIT;
      end
      S_ARMED: state_d = sensor ? S_ENTRY : S_ARMED;
      S_ENTRY: begin
        timed   = 1'b1;
        state_d = (tick && cnt_q == ENTRY_LAST) ? S_ALARM : S_ENTRY;
      end
      S_ALARM: begin
        // Without the timeout the counter stays parked at 0 and ALARM latches.
        timed   = TIMEOUT_EN;
        state_d = (TIMEOUT_EN && tick && cnt_q == ALARM_LAST) ? S_ARMED : S_ALARM;
      end
      default: state_d = S_DISARMED;
    endcase

    if (disarm) begin
      state_d = S_DISARMED;
    end

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && timed) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DISARMED;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      siren_q <= 1'b0;
      chirp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
      siren_q <= (state_d == S_ALARM);
      chirp_q <= (state_q == S_EXIT) && (state_d == S_ARMED);
    end
  end

  assign state = state_q;
  assign armed = armed_q;
  assign siren = siren_q;
  assign chirp = chirp_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: directed scenarios plus random traffic
// checked against a countdown-based behavioural model.
module tb_alarm_controller;

  localparam int EXIT_TICKS  = 10;
  localparam int ENTRY_TICKS = 8;
  localparam int ALARM_TICKS = 15;
`ifdef ALARM_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0, tick = 1'b0, arm = 1'b0, disarm = 1'b0, sensor = 1'b0;
  logic [2:0] state;
  logic       armed, siren, chirp;

  alarm_controller #(
    .EXIT_TICKS (EXIT_TICKS),
    .ENTRY_TICKS(ENTRY_TICKS),
    .ALARM_TICKS(ALARM_TICKS),
    .CW         (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .arm   (arm),
    .disarm(disarm),
    .sensor(sensor),
    .state (state),
    .armed (armed),
    .siren (siren),
    .chirp (chirp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       armed;
    logic       siren;
    logic       chirp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: state number plus ticks remaining before the current delay expires.
  int m_st  = 0;
  int m_rem = 0;
  bit m_chirp = 1'b0;

  task automatic apply(input bit r, input bit a, input bit d, input bit s, input bit t);
    int   nxt;
    exp_t e;
    @(negedge clk);
    rst = r; arm = a; disarm = d; sensor = s; tick = t;
    nxt = m_st;
    if (r) begin
      nxt = 0;
      m_chirp = 1'b0;
    end else begin
      if (d) nxt = 0;
      else begin
        case (m_st)
          0: if (a) nxt = 1;
          1: if (t) begin m_rem--; if (m_rem == 0) nxt = 2; end
          2: if (s) nxt = 3;
          3: if (t) begin m_rem--; if (m_rem == 0) nxt = 4; end
          4: if (TO && t) begin m_rem--; if (m_rem == 0) nxt = 2; end
          default: nxt = 0;
        endcase
      end
      m_chirp = (m_st == 1 && nxt == 2);
      if (nxt != m_st) begin
        case (nxt)
          1: m_rem = EXIT_TICKS;
          3: m_rem = ENTRY_TICKS;
          4: m_rem = ALARM_TICKS;
          default: m_rem = 0;
        endcase
      end
    end
    m_st = nxt;
    e.st    = 3'(m_st);
    e.armed = (m_st == 2 || m_st == 3 || m_st == 4);
    e.siren = (m_st == 4);
    e.chirp = m_chirp;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      idle(gap - 1);
      apply(0, 0, 0, 0, 1);
    end
  endtask

  // Monitor: DUT presents a fresh output every cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (state !== e.st || armed !== e.armed || siren !== e.siren || chirp !== e.chirp) begin
          miscompares++;
          $display("FAIL vec %0d outputs: got st=%0d armed=%0b siren=%0b chirp=%0b, want st=%0d armed=%0b siren=%0b chirp=%0b",
                   vectors, state, armed, siren, chirp, e.st, e.armed, e.siren, e.chirp);
        end else begin
          $display("vec %0d ok st=%0d armed=%0b siren=%0b chirp=%0b", vectors, state, armed, siren, chirp);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    // Reset, arm, exit delay, chirp.
    apply(1, 1, 1, 1, 1);
    apply(1, 0, 0, 0, 0);
    idle(2);
    apply(0, 1, 0, 0, 0);
    ticks(EXIT_TICKS, 16);
    idle(4);
    // Sensor trip, entry delay, alarm.
    apply(0, 0, 0, 1, 0);
    ticks(ENTRY_TICKS, 16);
    idle(3);
    // Alarm latches (or times out) across 30 ticks, then disarm.
    ticks(30, 4);
    idle(2);
    apply(0, 0, 1, 0, 0);
    idle(2);
    // Disarm coinciding with a tick during ENTRY.
    apply(0, 1, 0, 0, 0);
    ticks(EXIT_TICKS, 3);
    apply(0, 0, 0, 1, 0);
    ticks(5, 3);
    idle(2);
    apply(0, 0, 1, 1, 1);
    idle(3);
    // EXIT ignores sensor/arm, reset mid-delay, then arm with a simultaneous tick.
    apply(0, 1, 0, 0, 0);
    ticks(3, 2);
    apply(0, 1, 0, 1, 0);
    apply(1, 0, 1, 0, 1);
    idle(2);
    apply(0, 1, 0, 0, 1);
    ticks(EXIT_TICKS, 2);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0));
    end
    idle(1);
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter EXIT_TICKS, default 10: tick pulses spent in EXIT before arming; legal 1..2^CW-1.
REQ-002 Parameter ENTRY_TICKS, default 8: tick pulses spent in ENTRY before alarm; legal 1..2^CW-1.
REQ-003 Parameter ALARM_TICKS, default 15: tick pulses of siren before auto-rearm; used only with ALARM_TIMEOUT_EN.
REQ-004 Parameter CW, default 4: delay counter width.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tick  input  1  timebase pulse from the upstream 4-bit counter terminal count; each cycle high counts as one tick.
REQ-008 arm  input  1  arm request, level-sampled each cycle.
REQ-009 disarm  input  1  disarm request, level-sampled each cycle.
REQ-010 sensor  input  1  intrusion sensor, active-high, pre-synchronised.
REQ-011 state  output  3  current state code.
REQ-012 armed  output  1  high in ARMED, ENTRY, ALARM.
REQ-013 siren  output  1  high in ALARM only.
REQ-014 chirp  output  1  one-cycle pulse on first cycle of ARMED entered from EXIT.

Function
REQ-015 States SHALL be encoded DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5..7 SHALL go to DISARMED next cycle.
REQ-016 Outputs SHALL be Moore, decoded from the state register only; state change visible the cycle after the causing input.
REQ-017 disarm=1 SHALL force DISARMED next cycle from any state, overriding arm, sensor and tick in the same cycle.
REQ-018 DISARMED: arm=1 -> EXIT; otherwise hold.
REQ-019 EXIT: sensor ignored; arm ignored; when tick=1 and count=EXIT_TICKS-1 -> ARMED.
REQ-020 ARMED: sensor=1 -> ENTRY; tick ignored.
REQ-021 ENTRY: when tick=1 and count=ENTRY_TICKS-1 -> ALARM; sensor ignored.
REQ-022 ALARM: behaviour per REQ-029/REQ-030.
REQ-023 Delay counter (CW bits) SHALL clear to 0 on every state change and increment by 1 only on tick=1 while in EXIT, ENTRY or ALARM; never wraps (transition occurs first).
REQ-024 Tick on the same cycle as entering a timed state SHALL NOT be counted (counter clears on entry).
REQ-025 arm outside DISARMED SHALL have no effect.
REQ-026 chirp SHALL be high exactly one cycle, the first cycle state=ARMED after EXIT; not after ALARM timeout.

Reset
REQ-027 rst=1 at a clock edge SHALL set state=DISARMED, counter=0, armed=0, siren=0, chirp=0 on the following cycle, overriding all inputs including mid-delay or mid-alarm.
REQ-028 Reset SHALL take priority over disarm.

Configuration
REQ-029 With ALARM_TIMEOUT_EN defined: ALARM -> ARMED when tick=1 and count=ALARM_TICKS-1; siren drops in that same transition.
REQ-030 Without ALARM_TIMEOUT_EN: ALARM SHALL latch until disarm or rst; ALARM_TICKS unused; counter held at 0 in ALARM.

Verification
REQ-031 rst, arm=1 one cycle, then 10 tick pulses spaced 16 cycles -> state=EXIT until 10th tick, state=ARMED next cycle, chirp=1 exactly one cycle, armed=1.
REQ-032 ARMED, sensor=1 one cycle, then 8 ticks -> state=ENTRY, siren=0; after 8th tick state=ALARM, siren=1.
REQ-033 ENTRY after 5 ticks, disarm=1 same cycle as tick -> state=DISARMED, armed=0, siren=0; no ALARM entered.
REQ-034 ALARM, 15 ticks: with ALARM_TIMEOUT_EN -> state=ARMED, siren=0, chirp=0; without -> siren stays 1 after 30 ticks until disarm.
REQ-035 EXIT after 3 ticks, sensor=1 and arm=1 pulsed, then rst=1 -> sensor/arm ignored; after rst state=0, all outputs 0; arm with tick same cycle -> first tick not counted (ARMED after 10 further ticks).
